// File: rtl/rat_io_pkg.sv
// rtl/rat_io_pkg.sv - port map, CTRL/STATUS bit positions and shared types for the RAT I/O responder
package rat_io_pkg;

  typedef logic [7:0] io_port_t;

  localparam io_port_t PORT_SW     = 8'h20;
  localparam io_port_t PORT_RXDATA = 8'h21;
  localparam io_port_t PORT_STATUS = 8'h22;
  localparam io_port_t PORT_CTRL   = 8'h23;
  localparam io_port_t PORT_LEDS   = 8'h40;
  localparam io_port_t PORT_SSEG   = 8'h81;

  localparam int CTRL_IE      = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_POP     = 2;

  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_IE    = 3;
  localparam int STAT_OVF   = 4;

  function automatic io_port_t status_byte(input logic ovf, input logic ie,
                                           input logic full, input logic empty);
    io_port_t s;
    s             = '0;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_IE]    = ie;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/rat_io_fifo.sv
// rtl/rat_io_fifo.sv - RX byte FIFO with wrapping pointers and an explicit occupancy count
module rat_io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guarded locally so a stray pop on empty or push on full never moves a pointer
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rat_io_responder.sv
// rtl/rat_io_responder.sv - RAT MCU port-bus responder: output registers, read mux, RX FIFO and interrupt
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTR,
  input  logic [7:0] SWITCHES,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;

  logic wr_ctrl;
  logic ie;
  logic ie_next;
  logic ovf;
  logic ovf_next;
  logic empty_next;

  rat_io_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESET_N),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (RX_DATA),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  assign RX_READY  = ~fifo_full;
  assign wr_ctrl   = IO_STRB & (PORT_ID == PORT_CTRL);
  assign fifo_push = RX_VALID & ~fifo_full;
  assign fifo_pop  = wr_ctrl & OUT_PORT[CTRL_POP] & ~fifo_empty;

  // A byte arriving while full is dropped and flagged; the set beats a same-cycle clear
  assign ovf_next   = (RX_VALID & fifo_full) | (ovf & ~(wr_ctrl & OUT_PORT[CTRL_CLR_OVF]));
  assign ie_next    = wr_ctrl ? OUT_PORT[CTRL_IE] : ie;
  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign empty_next = (count_next == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LEDS <= '0;
      SSEG <= '0;
      ie   <= 1'b0;
      ovf  <= 1'b0;
      INTR <= 1'b0;
    end else begin
      if (IO_STRB && PORT_ID == PORT_LEDS) LEDS <= OUT_PORT;
      if (IO_STRB && PORT_ID == PORT_SSEG) SSEG <= OUT_PORT;
      ie   <= ie_next;
      ovf  <= ovf_next;
      INTR <= ie_next & (~empty_next | ovf_next);
    end
  end

  // Reads are side-effect free; the head byte is masked to zero when nothing is queued
  always_comb begin
    IN_PORT = '0;
    case (PORT_ID)
      PORT_SW:     IN_PORT = SWITCHES;
      PORT_RXDATA: IN_PORT = fifo_empty ? 8'h00 : fifo_dout;
      PORT_STATUS: IN_PORT = status_byte(ovf, ie, fifo_full, fifo_empty);
      default:     IN_PORT = '0;
    endcase
  end

endmodule

// File: tb/tb_rat_io_responder.sv
// tb/tb_rat_io_responder.sv - scoreboard bench for rat_io_responder against a queue-based reference model
module tb_rat_io_responder;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INTR;
  logic [7:0] SWITCHES;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] LEDS;
  logic [7:0] SSEG;

  rat_io_responder #(.FIFO_DEPTH(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .INTR    (INTR),
    .SWITCHES(SWITCHES),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID),
    .RX_READY(RX_READY),
    .LEDS    (LEDS),
    .SSEG    (SSEG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] id;
    logic [7:0] in_port;
    logic [7:0] leds;
    logic [7:0] sseg;
    logic       intr;
    logic       rx_ready;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: the FIFO is a plain byte queue, registers are plain variables
  logic [7:0] mq[$];
  logic       m_ie, m_ovf, m_intr;
  logic [7:0] m_leds, m_sseg;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ie   = 1'b0;
    m_ovf  = 1'b0;
    m_intr = 1'b0;
    m_leds = 8'h00;
    m_sseg = 8'h00;
  endfunction

  // Apply the inputs that were present at the clock edge just taken
  function automatic void model_step();
    bit was_full;
    bit ctrl;
    was_full = (mq.size() == 8);
    ctrl     = IO_STRB && (PORT_ID == 8'h23);
    if (ctrl && OUT_PORT[2] && mq.size() > 0) mq.delete(0);
    if (RX_VALID && !was_full) mq.push_back(RX_DATA);
    if (ctrl && OUT_PORT[1]) m_ovf = 1'b0;
    if (RX_VALID && was_full) m_ovf = 1'b1;
    if (ctrl) m_ie = OUT_PORT[0];
    if (IO_STRB && PORT_ID == 8'h40) m_leds = OUT_PORT;
    if (IO_STRB && PORT_ID == 8'h81) m_sseg = OUT_PORT;
    m_intr = m_ie && (mq.size() > 0 || m_ovf);
  endfunction

  function automatic logic [7:0] exp_in(input logic [7:0] id);
    logic [7:0] v;
    v = 8'h00;
    if (id == 8'h20) v = SWITCHES;
    else if (id == 8'h21) v = (mq.size() > 0) ? mq[0] : 8'h00;
    else if (id == 8'h22) begin
      v[1] = (mq.size() == 0);
      v[2] = (mq.size() == 8);
      v[3] = m_ie;
      v[4] = m_ovf;
    end
    return v;
  endfunction

  task automatic cyc(input bit strb, input logic [7:0] id, input logic [7:0] d,
                     input bit rxv, input logic [7:0] rxd, input logic [7:0] sw);
    exp_t e;
    @(posedge CLK);
    #1;
    model_step();
    IO_STRB  = strb;
    PORT_ID  = id;
    OUT_PORT = d;
    RX_VALID = rxv;
    RX_DATA  = rxd;
    SWITCHES = sw;
    e.id       = id;
    e.in_port  = exp_in(id);
    e.leds     = m_leds;
    e.sseg     = m_sseg;
    e.intr     = m_intr;
    e.rx_ready = (mq.size() < 8);
    sb.push_back(e);
  endtask

  task automatic idle_read(input logic [7:0] id);
    cyc(1'b0, id, 8'h00, 1'b0, 8'h00, 8'h3C);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk($sformatf("in_port id=%02h", mon_e.id), IN_PORT, mon_e.in_port);
        chk("leds", LEDS, mon_e.leds);
        chk("sseg", SSEG, mon_e.sseg);
        chk("intr", {7'b0, INTR}, {7'b0, mon_e.intr});
        chk("rx_ready", {7'b0, RX_READY}, {7'b0, mon_e.rx_ready});
      end
    end
  end

  initial begin
    logic [7:0] ids [8];
    int         wait_cnt;
    ids = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h23, 8'h23, 8'h40, 8'h81};

    RESET_N  = 1'b0;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h22;
    OUT_PORT = 8'h00;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    SWITCHES = 8'h00;
    model_reset();
    #2;
    chk("reset status", IN_PORT, 8'h02);
    chk("reset leds", LEDS, 8'h00);
    chk("reset sseg", SSEG, 8'h00);
    chk("reset intr", {7'b0, INTR}, 8'h00);
    chk("reset rx_ready", {7'b0, RX_READY}, 8'h01);
    PORT_ID = 8'h55;
    #1;
    chk("reset unmatched read", IN_PORT, 8'h00);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // Write then read mux
    cyc(1'b1, 8'h40, 8'hA5, 1'b0, 8'h00, 8'h00);
    idle_read(8'h20);
    idle_read(8'h55);

    // FIFO with interrupt enabled
    cyc(1'b1, 8'h23, 8'h01, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h22, 8'h00, 1'b1, 8'h11, 8'h00);
    cyc(1'b0, 8'h22, 8'h00, 1'b1, 8'h22, 8'h00);
    idle_read(8'h21);
    cyc(1'b1, 8'h23, 8'h05, 1'b0, 8'h00, 8'h00);
    idle_read(8'h21);
    cyc(1'b1, 8'h23, 8'h05, 1'b0, 8'h00, 8'h00);
    idle_read(8'h22);
    idle_read(8'h21);

    // Overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h22, 8'h00, 1'b1, 8'(i + 1), 8'h00);
    idle_read(8'h22);
    idle_read(8'h21);
    cyc(1'b1, 8'h23, 8'h03, 1'b0, 8'h00, 8'h00);
    idle_read(8'h22);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h23, 8'h05, 1'b0, 8'h00, 8'h00);
      idle_read(8'h21);
    end
    idle_read(8'h22);

    // Simultaneous push and pop, then pops on empty
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h22, 8'h00, 1'b1, 8'hA1 + 8'(i), 8'h00);
    cyc(1'b1, 8'h23, 8'h05, 1'b1, 8'hA4, 8'h00);
    idle_read(8'h21);
    idle_read(8'h22);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h23, 8'h05, 1'b0, 8'h00, 8'h00);
      idle_read(8'h22);
    end
    idle_read(8'h21);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h22, 8'h00, 1'b1, 8'hC0 + 8'(i), 8'h00);
    cyc(1'b1, 8'h40, 8'hFF, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 8'h81, 8'h5A, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 8'h23, 8'h01, 1'b0, 8'h00, 8'h00);
    idle_read(8'h22);
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("async rst leds", LEDS, 8'h00);
    chk("async rst sseg", SSEG, 8'h00);
    chk("async rst intr", {7'b0, INTR}, 8'h00);
    chk("async rst status", IN_PORT, 8'h02);
    chk("async rst rx_ready", {7'b0, RX_READY}, 8'h01);
    model_reset();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    idle_read(8'h21);

    // Randomized traffic alternating between fill-heavy and drain-heavy phases
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] id;
      int         pct;
      pct = ((i % 200) < 100) ? 40 : 5;
      id  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ids[$urandom_range(0, 7)];
      cyc(1'($urandom_range(0, 1)), id, 8'($urandom),
          ($urandom_range(0, 99) < pct), 8'($urandom), 8'($urandom));
    end
    idle_read(8'h22);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge CLK);
      wait_cnt++;
    end
    #1;
    chk("scoreboard drained", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
